// File: rtl/instr_cache.sv
// Direct-mapped read-only instruction cache with single-line refill FSM and FENCE.I invalidate.
// Optional hit/miss statistics counters are enabled by defining ICACHE_STATS_EN.
module instr_cache #(
  parameter int WIDTH       = 32,
  parameter int SETS        = 64,
  parameter int BLOCK_WORDS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic [WIDTH-1:0] addr,
  output logic [WIDTH-1:0] instr,
  output logic             hit,
  output logic             stall,
  input  logic             inv,
  output logic             mem_req,
  output logic [WIDTH-1:0] mem_addr,
  input  logic             mem_ready,
  input  logic [WIDTH-1:0] mem_rdata
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]      hit_count,
  output logic [31:0]      miss_count
`endif
);

  localparam int WB = $clog2(BLOCK_WORDS);
  localparam int IB = $clog2(SETS);
  localparam int OB = WB + 2;
  localparam int TW = WIDTH - OB - IB;

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_REFILL    = 2'd1;
  localparam logic [1:0] S_FILL_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [WB-1:0]    r_cnt;
  logic [IB-1:0]    r_idx;
  logic [TW-1:0]    r_tag;
  logic             r_abort;
  logic [SETS-1:0]  r_valid;
  logic [TW-1:0]    r_tags [SETS];
  logic [WIDTH-1:0] r_data [SETS*BLOCK_WORDS];

  logic [WB-1:0] w_word;
  logic [IB-1:0] w_idx;
  logic [TW-1:0] w_tag;
  logic          w_idle;
  logic          w_lookup_hit;
  logic          w_miss;
  logic          w_beat;
  logic          w_last;
  logic          w_unused_addr;

  assign w_word        = addr[OB-1:2];
  assign w_idx         = addr[OB+IB-1:OB];
  assign w_tag         = addr[WIDTH-1:OB+IB];
  assign w_unused_addr = ^addr[1:0];

  assign w_idle       = (r_state == S_IDLE);
  assign w_lookup_hit = w_idle & req & r_valid[w_idx] & (r_tags[w_idx] == w_tag);
  assign w_miss       = w_idle & req & ~w_lookup_hit;
  assign w_beat       = (r_state == S_REFILL) & mem_ready;
  assign w_last       = w_beat & (r_cnt == WB'(BLOCK_WORDS - 1));

  assign hit      = w_lookup_hit;
  assign instr    = r_data[{w_idx, w_word}];
  // Reset forces stall low even if the fetch stage still presents a request.
  assign stall    = rst & (w_miss | ~w_idle);
  assign mem_req  = (r_state == S_REFILL);
  assign mem_addr = mem_req ? {r_tag, r_idx, r_cnt, 2'b00} : {WIDTH{1'b0}};

  // Refill sequencing: latch the missing line, count beats, track aborts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= {WB{1'b0}};
      r_idx   <= {IB{1'b0}};
      r_tag   <= {TW{1'b0}};
      r_abort <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_abort <= 1'b0;
          if (w_miss) begin
            r_state <= S_REFILL;
            r_idx   <= w_idx;
            r_tag   <= w_tag;
            r_cnt   <= {WB{1'b0}};
          end
        end
        S_REFILL: begin
          if (inv) begin
            r_abort <= 1'b1;
          end
          if (w_beat) begin
            r_cnt <= r_cnt + WB'(1);
          end
          if (w_last) begin
            r_state <= S_FILL_DONE;
          end
        end
        S_FILL_DONE: begin
          r_state <= S_IDLE;
          r_abort <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_abort <= 1'b0;
        end
      endcase
    end
  end

  // Valid bits: invalidate always wins over a completing refill.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= {SETS{1'b0}};
    end else if (inv) begin
      r_valid <= {SETS{1'b0}};
    end else if (w_last && !r_abort) begin
      r_valid[r_idx] <= 1'b1;
    end
  end

  // Line data and tag storage; contents are qualified solely by the valid bits.
  always_ff @(posedge clk) begin
    if (w_beat) begin
      r_data[{r_idx, r_cnt}] <= mem_rdata;
    end
    if (w_last) begin
      r_tags[r_idx] <= r_tag;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] r_hit_count;
  logic [31:0] r_miss_count;

  // Saturating lookup statistics.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hit_count  <= 32'd0;
      r_miss_count <= 32'd0;
    end else begin
      if (w_lookup_hit && (r_hit_count != 32'hFFFF_FFFF)) begin
        r_hit_count <= r_hit_count + 32'd1;
      end
      if (w_miss && (r_miss_count != 32'hFFFF_FFFF)) begin
        r_miss_count <= r_miss_count + 32'd1;
      end
    end
  end

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;
`endif

endmodule
